// File: rtl/pipe_pkg.sv
// Shared types for the skid-buffer pipeline: per-stage occupancy state and its encodings.
package pipe_pkg;

    localparam logic [1:0] ENC_EMPTY = 2'b00;
    localparam logic [1:0] ENC_BUSY  = 2'b01;
    localparam logic [1:0] ENC_FULL  = 2'b10;

    typedef enum logic [1:0] {
        EMPTY = ENC_EMPTY,
        BUSY  = ENC_BUSY,
        FULL  = ENC_FULL
    } stage_state_t;

endpackage

// File: rtl/pipe_skid_stage.sv
// One registered skid stage: main register drives the output, skid register absorbs
// the word accepted in the cycle the downstream stalls, so in_ready is purely registered.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    stage_state_t      state, state_nxt;
    logic [DATA_W-1:0] main_q, main_nxt;
    logic [DATA_W-1:0] skid_q, skid_nxt;
    logic              in_xfer;
    logic              out_xfer;

    assign in_ready  = (state != FULL) && !reset;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt = BUSY;
                    main_nxt  = in_data;
                end
            end
            BUSY: begin
                if (in_xfer && out_xfer) begin
                    main_nxt = in_data;
                end else if (in_xfer) begin
                    state_nxt = FULL;
                    skid_nxt  = in_data;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                // skid always holds the younger word, so it moves up to main on drain
                if (out_xfer) begin
                    state_nxt = BUSY;
                    main_nxt  = skid_q;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state  <= EMPTY;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

endmodule

// File: rtl/pipe_skid_chain.sv
// STAGES chained skid stages with valid/ready backpressure and 1 word/cycle throughput.
// Optional PIPE_SKID_OCC_EN adds the occ port: registered count of words held in the chain.
module pipe_skid_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STAGES = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             flush,
    input  logic                             in_valid,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [DATA_W-1:0]                out_data,
    input  logic                             out_ready
`ifdef PIPE_SKID_OCC_EN
    ,
    output logic [$clog2(2*STAGES+1)-1:0]    occ
`endif
);

    logic [STAGES:0]   v;
    logic [STAGES:0]   r;
    logic [DATA_W-1:0] d [STAGES+1];

    assign v[0]      = in_valid;
    assign d[0]      = in_data;
    assign in_ready  = r[0];
    assign out_valid = v[STAGES];
    assign out_data  = d[STAGES];
    assign r[STAGES] = out_ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        pipe_skid_stage #(
            .DATA_W(DATA_W)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .in_valid (v[i]),
            .in_data  (d[i]),
            .in_ready (r[i]),
            .out_valid(v[i+1]),
            .out_data (d[i+1]),
            .out_ready(r[i+1])
        );
    end

`ifdef PIPE_SKID_OCC_EN
    localparam int OCC_W = $clog2(2*STAGES+1);

    logic [OCC_W-1:0] occ_q;
    logic             chain_in_xfer;
    logic             chain_out_xfer;

    assign chain_in_xfer  = in_valid && r[0];
    assign chain_out_xfer = v[STAGES] && out_ready;
    assign occ            = occ_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            occ_q <= '0;
        end else if (chain_in_xfer && !chain_out_xfer) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!chain_in_xfer && chain_out_xfer) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_chain.sv
// Scoreboard bench for pipe_skid_chain (DATA_W=8, STAGES=2); occ checked when PIPE_SKID_OCC_EN.
module tb_pipe_skid_chain;

    localparam int DATA_W = 8;
    localparam int STAGES = 2;
    localparam int OCC_W  = $clog2(2*STAGES+1);

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
`ifdef PIPE_SKID_OCC_EN
    logic [OCC_W-1:0]  occ;
`endif

    int unsigned       tests_run    = 0;
    int unsigned       tests_failed = 0;
    int unsigned       delivered    = 0;
    logic [DATA_W-1:0] sb_q [$];

    always #5 clk = ~clk;

    pipe_skid_chain #(
        .DATA_W(DATA_W),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
`ifdef PIPE_SKID_OCC_EN
        ,
        .occ      (occ)
`endif
    );

    // Scoreboard: push on accepted input, pop and compare on delivered output.
    always @(negedge clk) begin
        logic [DATA_W-1:0] exp_w;
        if (reset === 1'b1) begin
            sb_q.delete();
        end else begin
`ifdef PIPE_SKID_OCC_EN
            tests_run++;
            if (occ !== OCC_W'(sb_q.size())) begin
                tests_failed++;
                $display("FAIL occ_depth: got %0d expected %0d at %0t", occ, sb_q.size(), $time);
            end
`endif
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_unexpected: got %0h expected no word at %0t", out_data, $time);
                end else begin
                    exp_w = sb_q.pop_front();
                    if (out_data !== exp_w) begin
                        tests_failed++;
                        $display("FAIL sb_data: got %0h expected %0h at %0t", out_data, exp_w, $time);
                    end
                end
                delivered++;
            end
            if (flush === 1'b1) sb_q.delete();
            else if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(in_data);
        end
    end

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_state: got rdy=%b vld=%b data=%0h expected 0 0 0", in_ready, out_valid, out_data);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_streaming();
        int first = -1;
        int last  = -1;
        int got   = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid = (c < 16);
            in_data  = 8'(c + 1);
            @(negedge clk);
            if (c < 16) begin
                tests_run++;
                if (in_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stream_ready: got %b expected 1 at cycle %0d", in_ready, c);
                end
            end
            if (out_valid === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                tests_run++;
                if (out_data !== 8'(got + 1)) begin
                    tests_failed++;
                    $display("FAIL stream_order: got %0h expected %0h", out_data, got + 1);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        tests_run++;
        if (first != STAGES) begin
            tests_failed++;
            $display("FAIL stream_latency: got %0d expected %0d", first, STAGES);
        end
        tests_run++;
        if (got != 16 || last - first != 15) begin
            tests_failed++;
            $display("FAIL stream_gapless: got %0d words over %0d cycles expected 16 over 16", got, last - first + 1);
        end
    endtask

    task automatic test_backpressure();
        int  acc = 0;
        int  got = 0;
        bit  seen_ready = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hA0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c >= STAGES) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
                    tests_failed++;
                    $display("FAIL bp_stall_stable: got vld=%b data=%0h expected 1 a0", out_valid, out_data);
                end
            end
            if (in_ready === 1'b1) acc++;
            @(posedge clk); #1;
            in_data = 8'hA0 + 8'(acc);
        end
        tests_run++;
        if (acc != 2*STAGES) begin
            tests_failed++;
            $display("FAIL bp_capacity: got %0d expected %0d", acc, 2*STAGES);
        end
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_full_ready: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) seen_ready = 1'b1;
            if (out_valid === 1'b1) begin
                tests_run++;
                if (out_data !== 8'hA0 + 8'(got)) begin
                    tests_failed++;
                    $display("FAIL bp_drain_order: got %0h expected %0h", out_data, 8'hA0 + 8'(got));
                end
                got++;
            end
            @(posedge clk); #1;
        end
        tests_run++;
        if (got != 4 || !seen_ready) begin
            tests_failed++;
            $display("FAIL bp_drain: got %0d words ready=%b expected 4 words ready=1", got, seen_ready);
        end
    endtask

    task automatic test_flush();
        int acc = 0;
        int vcnt = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hB0;
        for (int c = 0; c < 10 && acc < 3; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) acc++;
            @(posedge clk); #1;
            in_data = 8'hB0 + 8'(acc);
        end
        tests_run++;
        if (acc != 3) begin
            tests_failed++;
            $display("FAIL flush_fill: got %0d expected 3", acc);
        end
        in_valid = 1'b1; in_data = 8'h55; flush = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_empty: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
`ifdef PIPE_SKID_OCC_EN
        tests_run++;
        if (occ !== '0) begin
            tests_failed++;
            $display("FAIL flush_occ: got %0d expected 0", occ);
        end
`endif
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) vcnt++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (vcnt != 0) begin
            tests_failed++;
            $display("FAIL flush_no_leak: got %0d valid cycles expected 0", vcnt);
        end
    endtask

    task automatic test_random();
        int unsigned sent = 0;
        int unsigned base = delivered;
        int unsigned cyc  = 0;
        while ((delivered - base) < 10000 && cyc < 60000) begin
            in_valid  = (sent < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data   = 8'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid === 1'b1 && in_ready === 1'b1) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if ((delivered - base) != 10000 || sent != 10000 || sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL random_complete: got sent=%0d delivered=%0d left=%0d expected 10000 10000 0",
                     sent, delivered - base, sb_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        int acc = 0;
        int vcnt = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC0;
        for (int c = 0; c < 12 && acc < 4; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) acc++;
            @(posedge clk); #1;
            in_data = 8'hC0 + 8'(acc);
        end
        tests_run++;
        if (acc != 4) begin
            tests_failed++;
            $display("FAIL midrst_fill: got %0d expected 4", acc);
        end
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL midrst_empty: got vld=%b rdy=%b data=%0h expected 0 1 0", out_valid, in_ready, out_data);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) vcnt++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (vcnt != 0) begin
            tests_failed++;
            $display("FAIL midrst_no_stale: got %0d valid cycles expected 0", vcnt);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
